// File: rtl/alu_result_fifo_if.sv
// Valid/ready result channel between ALU stages.
// Carries one ALU result word plus the func code that produced it.
interface alu_result_fifo_if #(
    parameter int DATA_W = 8,
    parameter int FUNC_W = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [FUNC_W-1:0] func;

    modport master (
        output valid,
        output data,
        output func,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  func,
        output ready
    );
endinterface

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 4-bit ALU.
// Queues tagged results for the consumer and feeds back the last low nibble as ALU B.
module alu_result_fifo #(
    parameter int DATA_W = 8,
    parameter int FUNC_W = 3,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clr,
    alu_result_fifo_if.slave   in_if,
    alu_result_fifo_if.master  out_if,
    output logic [3:0]         fb_operand,
    output logic [PTR_W:0]     count,
    output logic               drop_sticky
);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = FUNC_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       fb_q, fb_d;
    logic             drop_q, drop_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;

    // Flow control comes only from the registered occupancy.
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        push  = in_if.valid & ~full & ~clr;
        pop   = ~empty & out_if.ready & ~clr;
        head  = mem_q[rd_ptr_q];
    end

    assign in_if.ready  = ~full;
    assign out_if.valid = ~empty;
    assign out_if.data  = head[DATA_W-1:0];
    assign out_if.func  = head[ENT_W-1:DATA_W];
    assign fb_operand   = fb_q;
    assign count        = count_q;
    assign drop_sticky  = drop_q;

    // Next-state: clr overrides any push, pop or drop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fb_d     = fb_q;
        drop_d   = drop_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            fb_d     = '0;
            drop_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                fb_d     = in_if.data[3:0];
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (in_if.valid && full) begin
                drop_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fb_q     <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fb_q     <= fb_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array is not reset; out_valid guards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_if.func, in_if.data};
        end
    end
endmodule
